// File: rtl/sv_rebuild_pkg.sv
// Shared sizing for the SV level-vector rebuild path.
// Optional feature macro: THERMO_CHECK_EN (thermometer-code check on the rebuilt vector).
package sv_rebuild_pkg;

  // Ceiling log2 for elaboration-time width derivation.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

  localparam int unsigned N      = 18;
  localparam int unsigned CNT_W  = clog2(N + 1);
  localparam int unsigned ERRC_W = 8;

  localparam logic [ERRC_W-1:0] ERRC_MAX = '1;

endpackage

// File: rtl/sv_popcnt.sv
// Combinational population count of an N-bit vector.
module sv_popcnt #(
  parameter int unsigned N     = 18,
  parameter int unsigned CNT_W = 5
) (
  input  logic [N-1:0]     vec_i,
  output logic [CNT_W-1:0] cnt_o
);

  // Sum of all set bits.
  always_comb begin
    cnt_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cnt_o = cnt_o + CNT_W'(vec_i[i]);
    end
  end

endmodule

// File: rtl/sv_rebuild.sv
// Rebuilds the DAC element-select level vector from rise/fall event vectors,
// with event consistency checks and a one-entry registered output.
// Optional: define THERMO_CHECK_EN to flag non-thermometer level vectors.
module sv_rebuild
  import sv_rebuild_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      rise,
  input  logic [N-1:0]      fall,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      sv,
  output logic [CNT_W-1:0]  ones_cnt,
  output logic              err_conflict,
  output logic              err_redund,
  output logic [ERRC_W-1:0] redund_cnt,
  output logic              err_thermo
);

  // The level state and the presented sv are always loaded and cleared together,
  // so a single register serves both.
  logic [N-1:0]      sv_q;
  logic [CNT_W-1:0]  ones_cnt_q;
  logic              out_valid_q;
  logic              err_conflict_q;
  logic              err_redund_q;
  logic [ERRC_W-1:0] redund_cnt_q;

  logic [N-1:0]      conf_c;
  logic [N-1:0]      nxt_d;
  logic [CNT_W-1:0]  ones_cnt_d;
  logic              redund_c;
  logic              accept_c;

  // Handshake: a stalled output blocks input; clear drops any presented event.
  assign in_ready = ~clr & (~out_valid_q | out_ready);
  assign accept_c = in_valid & in_ready;

  // Next level: conflicting bits hold, otherwise fall clears and rise sets.
  always_comb begin
    conf_c   = rise & fall;
    nxt_d    = (conf_c & sv_q) | (~conf_c & ((sv_q & ~fall) | rise));
    redund_c = |(rise & sv_q & ~conf_c) | |(fall & ~sv_q & ~conf_c);
  end

  sv_popcnt #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_popcnt (
    .vec_i (nxt_d),
    .cnt_o (ones_cnt_d)
  );

  // Level state, output register and sticky error tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sv_q           <= '0;
      ones_cnt_q     <= '0;
      out_valid_q    <= 1'b0;
      err_conflict_q <= 1'b0;
      err_redund_q   <= 1'b0;
      redund_cnt_q   <= '0;
    end else if (clr) begin
      sv_q           <= '0;
      ones_cnt_q     <= '0;
      out_valid_q    <= 1'b0;
      err_conflict_q <= 1'b0;
      err_redund_q   <= 1'b0;
      redund_cnt_q   <= '0;
    end else if (accept_c) begin
      sv_q        <= nxt_d;
      ones_cnt_q  <= ones_cnt_d;
      out_valid_q <= 1'b1;
      if (|conf_c) err_conflict_q <= 1'b1;
      if (redund_c) begin
        err_redund_q <= 1'b1;
        if (redund_cnt_q != ERRC_MAX) redund_cnt_q <= redund_cnt_q + ERRC_W'(1);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef THERMO_CHECK_EN
  logic [N-1:0] nxt_inc_c;
  logic         err_thermo_q;

  // Thermometer code 0..01..1 is exactly the set of values v with v & (v+1) == 0.
  assign nxt_inc_c = nxt_d + N'(1);

  // Sticky thermometer violation flag on accepted results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_thermo_q <= 1'b0;
    end else if (clr) begin
      err_thermo_q <= 1'b0;
    end else if (accept_c && ((nxt_d & nxt_inc_c) != '0)) begin
      err_thermo_q <= 1'b1;
    end
  end

  assign err_thermo = err_thermo_q;
`else
  assign err_thermo = 1'b0;
`endif

  assign sv           = sv_q;
  assign ones_cnt     = ones_cnt_q;
  assign out_valid    = out_valid_q;
  assign err_conflict = err_conflict_q;
  assign err_redund   = err_redund_q;
  assign redund_cnt   = redund_cnt_q;

endmodule

// File: tb/tb_sv_rebuild.sv
// Scoreboard bench for sv_rebuild: directed scenarios plus random events,
// checked against a per-element level model.
module tb_sv_rebuild;
  import sv_rebuild_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      rise;
  logic [N-1:0]      fall;
  logic              out_valid;
  logic              out_ready;
  logic [N-1:0]      sv;
  logic [CNT_W-1:0]  ones_cnt;
  logic              err_conflict;
  logic              err_redund;
  logic [ERRC_W-1:0] redund_cnt;
  logic              err_thermo;

  sv_rebuild dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .rise         (rise),
    .fall         (fall),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .sv           (sv),
    .ones_cnt     (ones_cnt),
    .err_conflict (err_conflict),
    .err_redund   (err_redund),
    .redund_cnt   (redund_cnt),
    .err_thermo   (err_thermo)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sv_v;
    int cnt;
    bit ec;
    bit er;
    int rc;
    bit et;
  } exp_t;

  exp_t sb[$];
  bit   lvl[N];
  bit   m_ec, m_er, m_et;
  int   m_rc;
  int   total = 0;
  int   bad   = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) lvl[i] = 1'b0;
    m_ec = 0; m_er = 0; m_et = 0; m_rc = 0;
    sb.delete();
  endfunction

  // Applies one clock edge of the specified behaviour to the model.
  function automatic void model_edge();
    exp_t e;
    bit   red;
    int   v, c;
    if (clr) begin
      model_reset();
      return;
    end
    if (!(in_valid && sb.size() == 0)) return;
    red = 0;
    for (int i = 0; i < N; i++) begin
      if (rise[i] && fall[i]) m_ec = 1;
      else if (rise[i]) begin
        if (lvl[i]) red = 1;
        lvl[i] = 1;
      end else if (fall[i]) begin
        if (!lvl[i]) red = 1;
        lvl[i] = 0;
      end
    end
    if (red) begin
      m_er = 1;
      if (m_rc < 255) m_rc++;
    end
    v = 0; c = 0;
    for (int i = 0; i < N; i++) if (lvl[i]) begin v += (1 << i); c++; end
`ifdef THERMO_CHECK_EN
    for (int i = 1; i < N; i++) if (lvl[i] && !lvl[i-1]) m_et = 1;
`endif
    e.sv_v = v; e.cnt = c; e.ec = m_ec; e.er = m_er; e.rc = m_rc; e.et = m_et;
    sb.push_back(e);
  endfunction

  // Monitor: checks handshake every cycle and compares the presented result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("in_ready", int'(in_ready), int'(!clr && (sb.size() == 0 || out_ready)));
      chk("out_valid", int'(out_valid), int'(sb.size() != 0));
      if (sb.size() != 0 && out_valid) begin
        e = sb[0];
        chk("sv", int'(sv), e.sv_v);
        chk("ones_cnt", int'(ones_cnt), e.cnt);
        chk("err_conflict", int'(err_conflict), int'(e.ec));
        chk("err_redund", int'(err_redund), int'(e.er));
        chk("redund_cnt", int'(redund_cnt), e.rc);
        chk("err_thermo", int'(err_thermo), int'(e.et));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic step(input bit v, input logic [N-1:0] r, input logic [N-1:0] f,
                      input bit ordy, input bit c);
    in_valid = v; rise = r; fall = f; out_ready = ordy; clr = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_sv"}, int'(sv), 0);
    chk({tag, "_cnt"}, int'(ones_cnt), 0);
    chk({tag, "_ec"}, int'(err_conflict), 0);
    chk({tag, "_er"}, int'(err_redund), 0);
    chk({tag, "_rc"}, int'(redund_cnt), 0);
    chk({tag, "_et"}, int'(err_thermo), 0);
    chk({tag, "_ov"}, int'(out_valid), 0);
  endtask

  initial begin
    logic [N-1:0] r, f;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rise = '0; fall = '0;
    model_reset();
    #12 rst = 1'b0;
    check_cleared("reset");
    chk("reset_in_ready", int'(in_ready), 1);

    // Build-up and tear-down.
    step(1, N'('h00007), '0, 1, 0);
    step(1, N'('h00018), '0, 1, 0);
    step(1, '0, N'('h00018), 1, 0);
    step(1, '0, N'('h00007), 1, 0);
    step(0, '0, '0, 1, 0);

    // Conflict, redundant, saturation.
    step(1, N'('h00001), '0, 1, 0);
    step(1, N'('h00003), N'('h00002), 1, 0);
    step(1, N'('h00001), '0, 1, 0);
    for (int i = 0; i < 300; i++) step(1, N'('h00001), '0, 1, 0);
    step(0, '0, '0, 1, 0);
    chk("redund_sat", int'(redund_cnt), 255);

    // Empty event still produces a result.
    step(1, '0, '0, 1, 0);
    step(0, '0, '0, 1, 0);

    // Back-pressure: stalled result held, then consume and accept on one edge.
    step(1, '0, '0, 1, 1);
    step(1, N'('h00002), '0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, N'('h00004), '0, 0, 0);
    step(1, N'('h00004), '0, 1, 0);
    step(1, N'('h00008), '0, 1, 0);
    step(0, '0, '0, 1, 0);

    // Thermometer check then clear.
    step(0, '0, '0, 1, 1);
    step(1, N'('h00005), '0, 1, 0);
    step(0, '0, '0, 1, 0);
    step(1, N'('h00002), '0, 0, 1);
    check_cleared("clr");

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      r = N'($urandom) & N'($urandom);
      f = N'($urandom) & N'($urandom);
      step(($urandom_range(0, 3) != 0), r, f, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 99) == 0));
    end

    // Reset during a stall discards the pending result.
    step(1, N'('h00003), '0, 0, 0);
    step(1, N'('h00004), '0, 0, 0);
    in_valid = 0; rise = '0; fall = '0;
    #2 rst = 1'b1;
    #1;
    check_cleared("rst_stall");
    chk("rst_in_ready", int'(in_ready), 1);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    step(1, N'('h0000F), '0, 1, 0);
    step(0, '0, '0, 1, 0);
    step(0, '0, '0, 1, 0);
    chk("drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
